// File: rtl/neural_network.sv
// Two-layer MLP inference (input -> ReLU hidden -> linear outputs -> argmax), one input element per cycle.
// NNoutValid rises numInputs+L0neurons+numOutputs+3 edges after an accepted start; a held NNvalid never retriggers.
module neural_network #(
   parameter int numInputs       = 784,
   parameter int numOutputs      = 10,
   parameter int L0neurons       = 16,
   parameter int L1neurons       = 10,
   parameter int dataWidth       = 16,
   parameter int dataFracWidth   = 8,
   parameter int weightWidth     = 16,
   parameter int weightFracWidth = 8,
   parameter logic [weightWidth-1:0] L0wBase = 16'h0100,
   parameter logic [weightWidth-1:0] L0wStep = 16'h0000,
   parameter logic [weightWidth-1:0] L0bBase = 16'h0000,
   parameter logic [weightWidth-1:0] L0bStep = 16'h0000,
   parameter logic [weightWidth-1:0] L1wBase = 16'h0100,
   parameter logic [weightWidth-1:0] L1wStep = 16'h0000,
   parameter logic [weightWidth-1:0] L1bBase = 16'h0000,
   parameter logic [weightWidth-1:0] L1bStep = 16'h0010
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [numInputs*dataWidth-1:0]  NNin,
   input  logic                            NNvalid,
   output logic [numOutputs*dataWidth-1:0] NNout,
   output logic                            NNoutValid,
   output logic [3:0]                      maxIndex,
   output logic [dataWidth-1:0]            maxValue,
   output logic                            maxValid
);

   localparam int PROD_W = dataWidth + weightWidth;
   localparam int MAXN   = (numInputs > L0neurons) ? numInputs : L0neurons;
   localparam int ACC_W  = PROD_W + $clog2(MAXN) + 1;
   localparam int CNT_W  = $clog2(MAXN + 1);
   localparam int HID_W  = $clog2(L0neurons);
   localparam int OUT_W  = $clog2(numOutputs);
   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2**(dataWidth-1) - 1);
   localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

   typedef enum logic [2:0] {
      S_IDLE, S_L0, S_L0_ACT, S_L1, S_L1_ACT, S_ARGMAX, S_DONE
   } state_t;

   state_t                         r_state;
   state_t                         w_next;
   logic [CNT_W-1:0]               r_cnt;
   logic                           r_armed;
   logic                           r_done;
   logic [numInputs*dataWidth-1:0] r_nnin;
   logic signed [ACC_W-1:0]        r_acc0 [L0neurons];
   logic signed [ACC_W-1:0]        r_acc1 [L1neurons];
   logic [dataWidth-1:0]           r_hid  [L0neurons];
   logic [dataWidth-1:0]           r_out  [numOutputs];
   logic [3:0]                     r_best_idx;
   logic [3:0]                     r_max_idx;
   logic [dataWidth-1:0]           r_best_val;
   logic [dataWidth-1:0]           r_max_val;
   logic                           w_start;
   logic signed [dataWidth-1:0]    w_x0;
   logic signed [dataWidth-1:0]    w_x1;
   logic signed [dataWidth-1:0]    w_cand;
   logic signed [PROD_W-1:0]       w_prod0 [L0neurons];
   logic signed [PROD_W-1:0]       w_prod1 [L1neurons];

   // ROM images are affine fills: entry idx holds base + idx*step (wrapping).
   function automatic logic signed [weightWidth-1:0] rom_val(
      input logic [weightWidth-1:0] base,
      input logic [weightWidth-1:0] step,
      input int                     idx
   );
      logic [31:0] v;
      v = 32'(base) + 32'(idx) * 32'(step);
      return v[weightWidth-1:0];
   endfunction

   function automatic logic [dataWidth-1:0] activate(
      input logic signed [ACC_W-1:0]       acc,
      input logic signed [weightWidth-1:0] bias,
      input logic                          relu
   );
      logic signed [ACC_W-1:0] sum;
      logic signed [ACC_W-1:0] shr;
      logic [dataWidth-1:0]    res;
      sum = acc + (ACC_W'(bias) <<< dataFracWidth);
      shr = sum >>> weightFracWidth;
      if (shr > SAT_HI)
         res = {1'b0, {(dataWidth-1){1'b1}}};
      else if (shr < SAT_LO)
         res = {1'b1, {(dataWidth-1){1'b0}}};
      else
         res = shr[dataWidth-1:0];
      if (relu && res[dataWidth-1])
         res = '0;
      return res;
   endfunction

   assign w_start = ((r_state == S_IDLE) || (r_state == S_DONE)) && NNvalid && r_armed;
   assign w_x0    = r_nnin[r_cnt*dataWidth +: dataWidth];
   assign w_x1    = r_hid[r_cnt[HID_W-1:0]];
   assign w_cand  = r_out[r_cnt[OUT_W-1:0]];

   always_comb begin
      for (int n = 0; n < L0neurons; n++)
         w_prod0[n] = w_x0 * rom_val(L0wBase, L0wStep, n * numInputs + int'(r_cnt));
      for (int k = 0; k < L1neurons; k++)
         w_prod1[k] = w_x1 * rom_val(L1wBase, L1wStep, k * L0neurons + int'(r_cnt));
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: if (w_start) w_next = S_L0;
         S_L0:           if (r_cnt == CNT_W'(numInputs - 1)) w_next = S_L0_ACT;
         S_L0_ACT:       w_next = S_L1;
         S_L1:           if (r_cnt == CNT_W'(L0neurons - 1)) w_next = S_L1_ACT;
         S_L1_ACT:       w_next = S_ARGMAX;
         S_ARGMAX:       if (r_cnt == CNT_W'(numOutputs - 1)) w_next = S_DONE;
         default:        w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_armed   <= 1'b1;
         r_done    <= 1'b0;
         r_max_idx <= '0;
         r_max_val <= '0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state)
            r_cnt <= '0;
         else if (r_state inside {S_L0, S_L1, S_ARGMAX})
            r_cnt <= r_cnt + CNT_W'(1);
         // A start needs NNvalid seen low since the previous acceptance.
         if (!NNvalid)
            r_armed <= 1'b1;
         else if (w_start)
            r_armed <= 1'b0;
         if (w_start) begin
            r_done <= 1'b0;
         end else if (r_state == S_DONE) begin
            r_done    <= 1'b1;
            r_max_idx <= r_best_idx;
            r_max_val <= r_best_val;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_nnin     <= '0;
         r_best_idx <= '0;
         r_best_val <= '0;
         for (int n = 0; n < L0neurons; n++) begin
            r_acc0[n] <= '0;
            r_hid[n]  <= '0;
         end
         for (int k = 0; k < L1neurons; k++)
            r_acc1[k] <= '0;
         for (int k = 0; k < numOutputs; k++)
            r_out[k] <= '0;
      end else begin
         case (r_state)
            S_L0:
               for (int n = 0; n < L0neurons; n++)
                  r_acc0[n] <= r_acc0[n] + ACC_W'(w_prod0[n]);
            S_L0_ACT:
               for (int n = 0; n < L0neurons; n++)
                  r_hid[n] <= activate(r_acc0[n], rom_val(L0bBase, L0bStep, n), 1'b1);
            S_L1:
               for (int k = 0; k < L1neurons; k++)
                  r_acc1[k] <= r_acc1[k] + ACC_W'(w_prod1[k]);
            S_L1_ACT:
               for (int k = 0; k < L1neurons; k++)
                  r_out[k] <= activate(r_acc1[k], rom_val(L1bBase, L1bStep, k), 1'b0);
            S_ARGMAX:
               // Strictly-greater replace keeps the lowest index on ties.
               if ((r_cnt == '0) || (w_cand > $signed(r_best_val))) begin
                  r_best_val <= w_cand;
                  r_best_idx <= 4'(r_cnt);
               end
            default: ;
         endcase
         if (w_start) begin
            r_nnin <= NNin;
            for (int n = 0; n < L0neurons; n++)
               r_acc0[n] <= '0;
            for (int k = 0; k < L1neurons; k++)
               r_acc1[k] <= '0;
         end
      end
   end

   always_comb begin
      NNout = '0;
      for (int k = 0; k < numOutputs; k++)
         NNout[k*dataWidth +: dataWidth] = r_out[k];
   end

   assign NNoutValid = r_done;
   assign maxValid   = r_done;
   assign maxIndex   = r_max_idx;
   assign maxValue   = r_max_val;

endmodule

// File: tb/tb_neural_network.sv
// Directed bench: two engines share inputs; A has positive output weights and stepped biases,
// B has half-weight inputs, negative output weights and a flat bias so ties and negative saturation show.
module tb_neural_network;

   localparam int NI = 784;
   localparam int NO = 10;
   localparam int DW = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic [NI*DW-1:0] nn_in;
   logic             nn_vld;
   logic [NO*DW-1:0] a_out, b_out;
   logic             a_ovld, a_mvld, b_ovld, b_mvld;
   logic [3:0]       a_idx, b_idx;
   logic [15:0]      a_max, b_max;
   logic [NI*DW-1:0] v2, v3, v4, vr;
   int               n_total = 0;
   int               n_bad   = 0;

   always #5 clk = ~clk;

   neural_network #(
      .L0wBase(16'h0100), .L0wStep(16'h0000), .L0bBase(16'h0000), .L0bStep(16'h0000),
      .L1wBase(16'h0100), .L1wStep(16'h0000), .L1bBase(16'h0000), .L1bStep(16'h0010)
   ) u_dut_a (
      .clk(clk), .reset(reset), .NNin(nn_in), .NNvalid(nn_vld), .NNout(a_out),
      .NNoutValid(a_ovld), .maxIndex(a_idx), .maxValue(a_max), .maxValid(a_mvld)
   );

   neural_network #(
      .L0wBase(16'h0080), .L0wStep(16'h0000), .L0bBase(16'h0000), .L0bStep(16'h0000),
      .L1wBase(16'hFF00), .L1wStep(16'h0000), .L1bBase(16'h0100), .L1bStep(16'h0000)
   ) u_dut_b (
      .clk(clk), .reset(reset), .NNin(nn_in), .NNvalid(nn_vld), .NNout(b_out),
      .NNoutValid(b_ovld), .maxIndex(b_idx), .maxValue(b_max), .maxValid(b_mvld)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_inst(input string p, input logic [NO*DW-1:0] o, input logic ov,
                           input logic [3:0] mi, input logic [15:0] mv, input logic ml,
                           input logic [15:0] base, input logic [15:0] step,
                           input logic [3:0] ei, input logic [15:0] ev);
      logic [15:0] e;
      for (int k = 0; k < NO; k++) begin
         e = base + 16'(k) * step;
         chk($sformatf("%s_out%0d", p, k), 32'(o[k*DW +: DW]), 32'(e));
      end
      chk({p, "_outvld"}, 32'(ov), 32'd1);
      chk({p, "_maxvld"}, 32'(ml), 32'd1);
      chk({p, "_maxidx"}, 32'(mi), 32'(ei));
      chk({p, "_maxval"}, 32'(mv), 32'(ev));
   endtask

   task automatic chk_zero(input string p);
      chk({p, "_A_out"},  32'(|a_out), 32'd0);
      chk({p, "_A_vld"},  32'({a_ovld, a_mvld}), 32'd0);
      chk({p, "_A_max"},  32'({a_idx, a_max}), 32'd0);
      chk({p, "_B_out"},  32'(|b_out), 32'd0);
      chk({p, "_B_vld"},  32'({b_ovld, b_mvld}), 32'd0);
      chk({p, "_B_max"},  32'({b_idx, b_max}), 32'd0);
   endtask

   // Start a run, optionally holding NNvalid; otherwise scramble NNin after acceptance.
   task automatic run_vec(input logic [NI*DW-1:0] vec, input string tag, input bit hold);
      int lat;
      @(negedge clk);
      nn_vld = 1'b0;
      @(negedge clk);
      nn_in  = vec;
      nn_vld = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_clr_at_start"}, 32'({a_ovld, b_ovld, a_mvld, b_mvld}), 32'd0);
      if (!hold) begin
         nn_vld = 1'b0;
         nn_in  = ~vec;
      end
      lat = 0;
      while (!(a_ovld && b_ovld) && lat < 1000) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'd813);
   endtask

   initial begin
      int seen;
      v2 = '0; v2[15:0] = 16'h0100; v2[31:16] = 16'h0100;
      v3 = '0; v3[15:0] = 16'hFF00;
      v4 = {NI{16'h7FFF}};
      vr = '0; vr[15:0] = 16'h0001; vr[31:16] = 16'h0002;
      reset  = 1'b0;
      nn_vld = 1'b0;
      nn_in  = '0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      reset = 1'b1;

      // Two unit inputs: hidden 2.0 everywhere.
      run_vec(v2, "t2", 1'b1);
      chk_inst("t2A", a_out, a_ovld, a_idx, a_max, a_mvld, 16'h2000, 16'h0010, 4'd9, 16'h2090);
      chk_inst("t2B", b_out, b_ovld, b_idx, b_max, b_mvld, 16'hF100, 16'h0000, 4'd0, 16'hF100);
      repeat (30) @(negedge clk);
      chk("t5_hold_A_vld", 32'({a_ovld, a_mvld}), 32'd3);
      chk("t5_hold_B_vld", 32'({b_ovld, b_mvld}), 32'd3);
      chk("t5_hold_A_idx", 32'(a_idx), 32'd9);

      // Negative input is clamped by ReLU, outputs are bias only.
      run_vec(v3, "t3", 1'b0);
      chk_inst("t3A", a_out, a_ovld, a_idx, a_max, a_mvld, 16'h0000, 16'h0010, 4'd9, 16'h0090);
      chk_inst("t3B", b_out, b_ovld, b_idx, b_max, b_mvld, 16'h0100, 16'h0000, 4'd0, 16'h0100);

      // Full-scale inputs saturate hidden and outputs in both directions.
      run_vec(v4, "t4", 1'b0);
      chk_inst("t4A", a_out, a_ovld, a_idx, a_max, a_mvld, 16'h7FFF, 16'h0000, 4'd0, 16'h7FFF);
      chk_inst("t4B", b_out, b_ovld, b_idx, b_max, b_mvld, 16'h8000, 16'h0000, 4'd0, 16'h8000);

      // B hidden = (1+2)/256*0.5 -> 1.5 LSB truncated to 1 LSB.
      run_vec(vr, "tr", 1'b0);
      chk_inst("trA", a_out, a_ovld, a_idx, a_max, a_mvld, 16'h0030, 16'h0010, 4'd9, 16'h00C0);
      chk_inst("trB", b_out, b_ovld, b_idx, b_max, b_mvld, 16'h00F0, 16'h0000, 4'd0, 16'h00F0);

      // Reset in the middle of a run.
      @(negedge clk);
      nn_vld = 1'b0;
      @(negedge clk);
      nn_in  = v2;
      nn_vld = 1'b1;
      @(posedge clk);
      @(negedge clk);
      nn_vld = 1'b0;
      repeat (400) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk_zero("t6_midrun");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      seen = 0;
      repeat (900) begin
         @(negedge clk);
         if (a_ovld || b_ovld || a_mvld || b_mvld) seen++;
      end
      chk("t6_no_valid", 32'(seen), 32'd0);
      run_vec(v2, "t6", 1'b0);
      chk_inst("t6A", a_out, a_ovld, a_idx, a_max, a_mvld, 16'h2000, 16'h0010, 4'd9, 16'h2090);
      chk_inst("t6B", b_out, b_ovld, b_idx, b_max, b_mvld, 16'hF100, 16'h0000, 4'd0, 16'hF100);

      // Asynchronous reset between clock edges while results are held.
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk_zero("t1_async");
      @(negedge clk);
      reset = 1'b1;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
